instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
//
// PURPOSE
//   Sits directly downstream of the program counter.
//   - On request, reads the 16-bit instruction at the current PC over an
//     8-bit read bus, as two byte reads.
//   - Holds the assembled word for the decoder.
//   - When the decoder accepts the word, issues the one-cycle PC-increment
//     strobe.
//   - A flush (jump taken) aborts any in-flight fetch.
//
// PARAMETERS
//   ADDR_WIDTH  16  byte address width of PC and memory bus
//   BIG_ENDIAN  1   1: even byte -> instr[15:8]; 0: even byte -> instr[7:0]
//
// PORTS
//   clk_in            in   1           clock; all state updates on rising edge
//   reset_n_in        in   1           asynchronous, active-low reset
//   pc_in             in   ADDR_WIDTH  address from program counter; bit0 ignored
//   fetch_req_in      in   1           controller requests a fetch at pc_in
//   flush_in          in   1           abort fetch and drop held instruction
//   mem_addr_out      out  ADDR_WIDTH  byte address of current read
//   mem_rd_req_out    out  1           read request, level
//   mem_rd_ack_in     in   1           read complete; data valid this cycle
//   mem_rd_data_in    in   8           read data
//   instr_out         out  16          assembled instruction
//   instr_valid_out   out  1           instr_out valid, held until accepted
//   instr_ready_in    in   1           decoder accepts instr_out
//   pc_update_en_out  out  1           1-cycle strobe to PC (increment select)
//   busy_out          out  1           state != IDLE
//
// BEHAVIOUR
//   Reset (reset_n_in low, asynchronous)
//     - State -> IDLE.
//     - Address latch = 0 and instr_out = 0x0000.
//     - instr_valid_out, mem_rd_req_out, pc_update_en_out and busy_out = 0.
//     - Reset mid-read drops the request immediately; the partial byte is lost.
//
//   State machine: IDLE -> RD0 -> RD1 -> HOLD -> IDLE
//   - IDLE
//     - If fetch_req_in & !flush_in: latch addr = {pc_in[15:1], 1'b0}
//       and go to RD0.
//   - RD0
//     - mem_rd_req_out = 1, mem_addr_out = addr.
//     - On ack: capture the byte and go to RD1.
//   - RD1
//     - mem_rd_req_out = 1, mem_addr_out = addr | 1.
//     - On ack: capture the byte, set instr_valid_out and go to HOLD.
//   - HOLD
//     - instr_valid_out = 1 and instr_out is stable.
//     - If instr_ready_in: pc_update_en_out = 1 this cycle (combinational
//       valid & ready), clear valid and go to IDLE.
//
//   Handshake and timing rules
//     - mem_rd_req_out and mem_addr_out are decoded from state, so they are
//       glitch-free.
//     - Ack may arrive in the same cycle as the request; zero-wait memory gives
//       RD0 and RD1 one cycle each.
//     - Minimum latency from fetch_req_in to instr_valid_out is 3 edges.
//     - The bus has no outstanding transactions: memory may ack only while
//       req is high.
//     - Ack sampled outside RD0/RD1 is ignored.
//     - fetch_req_in is ignored outside IDLE.
//     - The new fetch starts on the edge after the IDLE cycle; there is no
//       HOLD -> RD0 bypass.
//
//   Flush and simultaneous events
//     - flush_in in any state: next state IDLE and valid cleared.
//     - A same-cycle ack is discarded; instr_out keeps its old value.
//     - flush with instr_ready_in in HOLD: flush wins; pc_update_en_out = 0.
//     - flush with fetch_req_in in IDLE: flush wins; no fetch starts.
//
//   Address width and wrap
//     - No carry into upper bits: pc 0xFFFE reads 0xFFFE then 0xFFFF.
//     - pc_in is sampled once, in IDLE; later pc_in changes do not affect the
//       fetch in progress.
//
// TESTING
//   1. Zero-wait memory, BIG_ENDIAN=1, pc_in=0x0010, bytes 0xA5 then 0x3C,
//      ready tied 1 -> addrs 0x0010, 0x0011; instr_out=0xA53C valid 1 cycle;
//      one pc_update_en_out pulse.
//   2. BIG_ENDIAN=0, same stimulus -> instr_out=0x3CA5.
//   3. Ack delayed 3 cycles per byte, ready held 0 for 5 cycles ->
//      req/addr stable while waiting; valid held 5 cycles, instr stable;
//      a single pc_update_en_out pulse on accept.
//   4. Flush in RD1 with a same-cycle ack -> IDLE next cycle, valid never
//      rises, no pc_update, instr_out unchanged; a flush in HOLD with ready=1
//      also gives no pulse.
//   5. pc_in=0xFFFF -> addrs 0xFFFE, 0xFFFF (bit0 ignored, no wrap to
//      0x0000); reset_n_in pulsed low in RD1 -> req=0 immediately and all
//      outputs at reset values.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches a 16-bit instruction at the PC as two byte reads and hands it to the decoder
//   clk_in/reset_n_in         clock, asynchronous active-low reset
//   pc_in, fetch_req_in       fetch request at pc_in (bit0 ignored), sampled in IDLE only
//   flush_in                  aborts any fetch and drops the held instruction
//   mem_addr_out/mem_rd_*     8-bit read bus: level request, ack means data valid this cycle
//   instr_out/instr_valid_out assembled word, held until instr_ready_in
//   pc_update_en_out          one-cycle strobe on decoder accept
//   busy_out                  fetch unit not idle
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  reset_n_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  fetch_req_in,
  input  logic                  flush_in,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic                  mem_rd_req_out,
  input  logic                  mem_rd_ack_in,
  input  logic [7:0]            mem_rd_data_in,
  output logic [15:0]           instr_out,
  output logic                  instr_valid_out,
  input  logic                  instr_ready_in,
  output logic                  pc_update_en_out,
  output logic                  busy_out
);
  typedef enum logic [1:0] {IDLE, RD0, RD1, HOLD} state_e;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            byte_q, byte_d;
  logic [15:0]           instr_q, instr_d;
  logic                  unused_pc0;
  assign unused_pc0 = pc_in[0];
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= IDLE;
      addr_q  <= '0;
      byte_q  <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      instr_q <= instr_d;
    end
  end
  // A flush leaves every data register untouched, so a same-cycle ack is simply discarded.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    byte_d  = byte_q;
    instr_d = instr_q;
    if (flush_in) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (fetch_req_in) begin
          state_d = RD0;
          addr_d  = {pc_in[ADDR_WIDTH-1:1], 1'b0};
        end
        RD0: if (mem_rd_ack_in) begin
          state_d = RD1;
          byte_d  = mem_rd_data_in;
        end
        RD1: if (mem_rd_ack_in) begin
          state_d = HOLD;
          instr_d = BIG_ENDIAN ? {byte_q, mem_rd_data_in} : {mem_rd_data_in, byte_q};
        end
        HOLD: if (instr_ready_in) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  // Bus outputs depend on registered state only, so they cannot glitch.
  assign mem_rd_req_out   = (state_q == RD0) || (state_q == RD1);
  assign mem_addr_out     = {addr_q[ADDR_WIDTH-1:1], state_q == RD1};
  assign instr_out        = instr_q;
  assign instr_valid_out  = state_q == HOLD;
  assign pc_update_en_out = instr_valid_out && instr_ready_in && !flush_in;
  assign busy_out         = state_q != IDLE;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized self-checking bench for both endianness variants
module tb_instruction_fetch_unit;
  logic        clk_in = 1'b0;
  logic        reset_n_in, fetch_req_in, flush_in, mem_rd_ack_in, instr_ready_in;
  logic [15:0] pc_in;
  logic [7:0]  mem_rd_data_in;
  logic [15:0] addr_b, addr_l, instr_b, instr_l;
  logic        req_b, req_l, valid_b, valid_l, upd_b, upd_l, busy_b, busy_l;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  mem [logic [15:0]];
  logic [15:0] exp_b = 16'h0000;
  logic [15:0] exp_l = 16'h0000;
  always #5 clk_in = ~clk_in;
  instruction_fetch_unit #(.ADDR_WIDTH(16), .BIG_ENDIAN(1'b1)) dut_b (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .pc_in(pc_in), .fetch_req_in(fetch_req_in),
    .flush_in(flush_in), .mem_addr_out(addr_b), .mem_rd_req_out(req_b),
    .mem_rd_ack_in(mem_rd_ack_in), .mem_rd_data_in(mem_rd_data_in), .instr_out(instr_b),
    .instr_valid_out(valid_b), .instr_ready_in(instr_ready_in), .pc_update_en_out(upd_b),
    .busy_out(busy_b));
  instruction_fetch_unit #(.ADDR_WIDTH(16), .BIG_ENDIAN(1'b0)) dut_l (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .pc_in(pc_in), .fetch_req_in(fetch_req_in),
    .flush_in(flush_in), .mem_addr_out(addr_l), .mem_rd_req_out(req_l),
    .mem_rd_ack_in(mem_rd_ack_in), .mem_rd_data_in(mem_rd_data_in), .instr_out(instr_l),
    .instr_valid_out(valid_l), .instr_ready_in(instr_ready_in), .pc_update_en_out(upd_l),
    .busy_out(busy_l));
  function automatic logic [7:0] byte_at(input logic [15:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction
  task automatic step;
    @(posedge clk_in);
    #1;
  endtask
  task automatic idle_inputs;
    fetch_req_in = 1'b0;
    flush_in = 1'b0;
    mem_rd_ack_in = 1'b0;
    mem_rd_data_in = 8'h00;
    instr_ready_in = 1'b0;
  endtask
  task automatic run_fetch(input logic [15:0] pc, input int d0, input int d1, input int wait_rdy,
                           input bit rdy_tied);
    logic [15:0] e;
    logic [7:0]  b0, b1;
    e = {pc[15:1], 1'b0};
    b0 = byte_at(e);
    b1 = byte_at(e | 16'h0001);
    pc_in = pc;
    fetch_req_in = 1'b1;
    instr_ready_in = rdy_tied;
    @(negedge clk_in);
    checks++;
    if ({busy_b, busy_l, valid_b, valid_l, req_b} !== 5'b0) begin
      errors++;
      $display("FAIL fetch_idle: busy=%b valid=%b req=%b expected all 0", busy_b, valid_b, req_b);
    end
    step;
    fetch_req_in = 1'b0;
    pc_in = 16'($urandom);
    for (int d = 0; d <= d0; d++) begin
      mem_rd_ack_in = (d == d0);
      mem_rd_data_in = (d == d0) ? b0 : 8'($urandom);
      @(negedge clk_in);
      checks++;
      if ({req_b, req_l, upd_b, upd_l, valid_b, valid_l} !== 6'b110000 || addr_b !== e || addr_l !== e) begin
        errors++;
        $display("FAIL rd0: req=%b%b upd=%b valid=%b addr=%h/%h expected req=11 upd=0 valid=0 addr=%h",
                 req_b, req_l, upd_b, valid_b, addr_b, addr_l, e);
      end
      step;
    end
    for (int d = 0; d <= d1; d++) begin
      mem_rd_ack_in = (d == d1);
      mem_rd_data_in = (d == d1) ? b1 : 8'($urandom);
      @(negedge clk_in);
      checks++;
      if ({req_b, req_l, upd_b, upd_l, valid_b, valid_l} !== 6'b110000 ||
          addr_b !== (e | 16'h1) || addr_l !== (e | 16'h1)) begin
        errors++;
        $display("FAIL rd1: req=%b%b upd=%b valid=%b addr=%h/%h expected req=11 upd=0 valid=0 addr=%h",
                 req_b, req_l, upd_b, valid_b, addr_b, addr_l, e | 16'h1);
      end
      step;
    end
    exp_b = {b0, b1};
    exp_l = {b1, b0};
    for (int w = 0; w <= wait_rdy; w++) begin
      instr_ready_in = (w == wait_rdy);
      mem_rd_ack_in = 1'($urandom);
      mem_rd_data_in = 8'($urandom);
      @(negedge clk_in);
      checks++;
      if ({valid_b, valid_l, req_b, req_l} !== 4'b1100 || instr_b !== exp_b || instr_l !== exp_l ||
          {upd_b, upd_l} !== {2{w == wait_rdy}}) begin
        errors++;
        $display("FAIL hold: valid=%b req=%b instr=%h/%h upd=%b%b expected valid=1 req=0 instr=%h/%h upd=%0d",
                 valid_b, req_b, instr_b, instr_l, upd_b, upd_l, exp_b, exp_l, w == wait_rdy);
      end
      step;
    end
    instr_ready_in = 1'b0;
    mem_rd_ack_in = 1'($urandom);
    @(negedge clk_in);
    checks++;
    if ({valid_b, valid_l, busy_b, busy_l, upd_b, upd_l, req_b} !== 7'b0 || instr_b !== exp_b || instr_l !== exp_l) begin
      errors++;
      $display("FAIL after_accept: valid=%b busy=%b upd=%b req=%b instr=%h/%h expected zeros instr=%h/%h",
               valid_b, busy_b, upd_b, req_b, instr_b, instr_l, exp_b, exp_l);
    end
    idle_inputs();
    step;
  endtask
  task automatic test_reset;
    idle_inputs();
    pc_in = 16'h1234;
    reset_n_in = 1'b0;
    step;
    step;
    @(negedge clk_in);
    checks++;
    if ({req_b, valid_b, upd_b, busy_b, req_l, valid_l, busy_l} !== 7'b0 ||
        instr_b !== 16'h0 || instr_l !== 16'h0 || addr_b !== 16'h0) begin
      errors++;
      $display("FAIL reset: req=%b valid=%b upd=%b busy=%b instr=%h addr=%h expected zeros",
               req_b, valid_b, upd_b, busy_b, instr_b, addr_b);
    end
    reset_n_in = 1'b1;
    step;
  endtask
  task automatic test_zero_wait;
    mem[16'h0010] = 8'hA5;
    mem[16'h0011] = 8'h3C;
    run_fetch(16'h0010, 0, 0, 0, 1'b1);
    checks++;
    if (instr_b !== 16'hA53C || instr_l !== 16'h3CA5) begin
      errors++;
      $display("FAIL endian: instr=%h/%h expected A53C/3CA5", instr_b, instr_l);
    end
  endtask
  task automatic test_wait_states;
    run_fetch(16'h0246, 3, 3, 5, 1'b0);
  endtask
  task automatic test_flush;
    logic [15:0] old_b, old_l, e;
    old_b = exp_b;
    old_l = exp_l;
    pc_in = 16'h0400;
    fetch_req_in = 1'b1;
    step;
    fetch_req_in = 1'b0;
    mem_rd_ack_in = 1'b1;
    mem_rd_data_in = 8'h11;
    step;
    mem_rd_data_in = 8'h22;
    flush_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({req_b, upd_b, upd_l, valid_b} !== 4'b1000) begin
      errors++;
      $display("FAIL flush_rd1: req=%b upd=%b%b valid=%b expected req=1 upd=0 valid=0", req_b, upd_b, upd_l, valid_b);
    end
    step;
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_in);
      checks++;
      if ({busy_b, valid_b, valid_l, upd_b, req_b} !== 5'b0 || instr_b !== old_b || instr_l !== old_l) begin
        errors++;
        $display("FAIL flush_rd1_after: busy=%b valid=%b upd=%b req=%b instr=%h/%h expected zeros instr=%h/%h",
                 busy_b, valid_b, upd_b, req_b, instr_b, instr_l, old_b, old_l);
      end
      step;
    end
    fetch_req_in = 1'b1;
    step;
    fetch_req_in = 1'b0;
    mem_rd_ack_in = 1'b1;
    flush_in = 1'b1;
    step;
    idle_inputs();
    @(negedge clk_in);
    checks++;
    if ({busy_b, req_b, valid_b} !== 3'b0 || instr_b !== old_b) begin
      errors++;
      $display("FAIL flush_rd0: busy=%b req=%b valid=%b instr=%h expected zeros instr=%h",
               busy_b, req_b, valid_b, instr_b, old_b);
    end
    step;
    e = 16'h0830;
    pc_in = e;
    fetch_req_in = 1'b1;
    step;
    fetch_req_in = 1'b0;
    mem_rd_ack_in = 1'b1;
    mem_rd_data_in = byte_at(e);
    step;
    mem_rd_data_in = byte_at(e | 16'h1);
    step;
    exp_b = {byte_at(e), byte_at(e | 16'h1)};
    exp_l = {byte_at(e | 16'h1), byte_at(e)};
    mem_rd_ack_in = 1'b0;
    instr_ready_in = 1'b1;
    flush_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({valid_b, upd_b, upd_l} !== 3'b100 || instr_b !== exp_b || instr_l !== exp_l) begin
      errors++;
      $display("FAIL flush_hold: valid=%b upd=%b%b instr=%h/%h expected valid=1 upd=00 instr=%h/%h",
               valid_b, upd_b, upd_l, instr_b, instr_l, exp_b, exp_l);
    end
    step;
    idle_inputs();
    @(negedge clk_in);
    checks++;
    if ({valid_b, busy_b, upd_b} !== 3'b0) begin
      errors++;
      $display("FAIL flush_hold_after: valid=%b busy=%b upd=%b expected 000", valid_b, busy_b, upd_b);
    end
    step;
    fetch_req_in = 1'b1;
    flush_in = 1'b1;
    step;
    idle_inputs();
    @(negedge clk_in);
    checks++;
    if ({busy_b, busy_l, req_b} !== 3'b0) begin
      errors++;
      $display("FAIL flush_idle: busy=%b req=%b expected 0 0", busy_b, req_b);
    end
    step;
  endtask
  task automatic test_wrap_and_reset;
    pc_in = 16'hFFFF;
    fetch_req_in = 1'b1;
    step;
    fetch_req_in = 1'b0;
    pc_in = 16'h0000;
    @(negedge clk_in);
    checks++;
    if (addr_b !== 16'hFFFE || req_b !== 1'b1) begin
      errors++;
      $display("FAIL wrap_rd0: addr=%h req=%b expected FFFE 1", addr_b, req_b);
    end
    mem_rd_ack_in = 1'b1;
    step;
    mem_rd_ack_in = 1'b0;
    @(negedge clk_in);
    checks++;
    if (addr_b !== 16'hFFFF || req_b !== 1'b1) begin
      errors++;
      $display("FAIL wrap_rd1: addr=%h req=%b expected FFFF 1", addr_b, req_b);
    end
    #1;
    reset_n_in = 1'b0;
    #1;
    checks++;
    if ({req_b, req_l, busy_b, valid_b, upd_b} !== 5'b0 || instr_b !== 16'h0 || addr_b !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_read: req=%b busy=%b valid=%b upd=%b instr=%h addr=%h expected zeros",
               req_b, busy_b, valid_b, upd_b, instr_b, addr_b);
    end
    exp_b = 16'h0;
    exp_l = 16'h0;
    step;
    reset_n_in = 1'b1;
    step;
    run_fetch(16'hFFFE, 0, 1, 1, 1'b0);
  endtask
  task automatic test_random;
    for (int n = 0; n < 25; n++)
      run_fetch(16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), 1'($urandom));
  endtask
  initial begin
    idle_inputs();
    pc_in = 16'h0;
    reset_n_in = 1'b0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_flush();
    test_wrap_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
